// File: rtl/fx_pkg.sv
// Shared types and default formats for the fixed-point format converter.
// Fx<M,B> is a two's-complement word of 1+B bits with M integer bits and B-M fraction bits.
package fx_pkg;

    typedef enum logic [1:0] {
        TRUNC = 2'd0,
        RNE   = 2'd1,
        RHU   = 2'd2,
        RSVD  = 2'd3
    } round_mode_t;

    localparam int FX_M_IN_DEF  = 8;
    localparam int FX_B_IN_DEF  = 24;
    localparam int FX_M_OUT_DEF = 4;
    localparam int FX_B_OUT_DEF = 12;
    localparam int CNT_W        = 16;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/fx_round.sv
// Combinational fraction alignment and rounding into output-LSB units.
// D > 0 drops D fraction bits with guard/sticky rounding; D <= 0 shifts left exactly.
module fx_round
    import fx_pkg::*;
#(
    parameter int W_IN = 25,
    parameter int D    = 8,
    parameter int RW   = 26
) (
    input  logic signed [W_IN-1:0] value,
    input  round_mode_t            mode,
    output logic signed [RW-1:0]   rounded,
    output logic                   inexact
);

    logic signed [RW-1:0] ext;

    assign ext = {{(RW-W_IN){value[W_IN-1]}}, value};

    if (D > 0) begin : g_narrow
        logic                 guard;
        logic                 sticky;
        logic                 lsb;
        logic                 inc;
        logic signed [RW-1:0] floor_v;

        assign floor_v = ext >>> D;
        assign guard   = value[D-1];
        assign lsb     = value[D];

        if (D > 1) begin : g_sticky
            assign sticky = |value[D-2:0];
        end else begin : g_no_sticky
            assign sticky = 1'b0;
        end

        always_comb begin
            inc = 1'b0;
            case (mode)
                RNE:     inc = guard & (sticky | lsb);
                RHU:     inc = guard;
                default: inc = 1'b0;
            endcase
        end

        // RW carries a spare MSB so the increment carry out of the top magnitude bit survives
        assign rounded = floor_v + $signed({{(RW-1){1'b0}}, inc});
        assign inexact = guard | sticky;
    end else begin : g_widen
        assign rounded = ext <<< (-D);
        assign inexact = 1'b0;
    end

endmodule

// File: rtl/fx_convert_stream.sv
// Streaming Fx<FX_M_IN,FX_B_IN> -> Fx<FX_M_OUT,FX_B_OUT> converter with rounding, saturation,
// a two-stage valid/ready pipeline and a saturating overflow event counter.
module fx_convert_stream
    import fx_pkg::*;
#(
    parameter int FX_M_IN  = FX_M_IN_DEF,
    parameter int FX_B_IN  = FX_B_IN_DEF,
    parameter int FX_M_OUT = FX_M_OUT_DEF,
    parameter int FX_B_OUT = FX_B_OUT_DEF
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      in_valid_i,
    output logic                      in_ready_o,
    input  logic signed [FX_B_IN:0]   fixed_i,
    input  logic        [1:0]         round_mode_i,
    input  logic                      sat_en_i,
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output logic signed [FX_B_OUT:0]  fixed_o,
    output logic                      ovf_o,
    output logic                      inexact_o,
    input  logic                      clr_count_i,
    output logic        [CNT_W-1:0]   ovf_count_o
);

    localparam int W_IN  = FX_B_IN + 1;
    localparam int W_OUT = FX_B_OUT + 1;
    localparam int F_IN  = FX_B_IN - FX_M_IN;
    localparam int F_OUT = FX_B_OUT - FX_M_OUT;
    localparam int D     = F_IN - F_OUT;
    localparam int SHL   = (D < 0) ? -D : 0;
    localparam int RW    = max_int(W_IN + SHL + 1, W_OUT + 1);

    localparam logic signed [RW-1:0] MAX_V = {{(RW-FX_B_OUT){1'b0}}, {FX_B_OUT{1'b1}}};
    localparam logic signed [RW-1:0] MIN_V = {{(RW-FX_B_OUT){1'b1}}, {FX_B_OUT{1'b0}}};

    // Returns {ovf, word}: clamps on overflow when sat is set, otherwise keeps the low bits.
    function automatic logic [W_OUT:0] saturate(input logic signed [RW-1:0] v, input logic sat);
        logic             hi;
        logic             lo;
        logic [W_OUT-1:0] word;
        hi = (v > MAX_V);
        lo = (v < MIN_V);
        if (sat && hi)
            word = MAX_V[W_OUT-1:0];
        else if (sat && lo)
            word = MIN_V[W_OUT-1:0];
        else
            word = v[W_OUT-1:0];
        return {hi | lo, word};
    endfunction

    logic                    load_p1;
    logic                    load_p2;
    logic signed [RW-1:0]    rnd_p0;
    logic                    inexact_p0;
    logic                    vld_p1;
    logic signed [RW-1:0]    rnd_p1;
    logic                    inexact_p1;
    logic                    sat_p1;
    logic        [W_OUT:0]   sat_res_p1;
    logic                    vld_p2;
    logic signed [W_OUT-1:0] fixed_p2;
    logic                    ovf_p2;
    logic                    inexact_p2;
    logic        [CNT_W-1:0] ovf_count;

    assign load_p2    = !vld_p2 || out_ready_i;
    assign load_p1    = !vld_p1 || load_p2;
    assign in_ready_o = load_p1;

    // ---- stage 0 -> 1: align and round ----
    fx_round #(
        .W_IN (W_IN),
        .D    (D),
        .RW   (RW)
    ) u_round (
        .value   (fixed_i),
        .mode    (round_mode_t'(round_mode_i)),
        .rounded (rnd_p0),
        .inexact (inexact_p0)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            vld_p1 <= 1'b0;
        else if (load_p1)
            vld_p1 <= in_valid_i;
    end

    always_ff @(posedge clk_i) begin
        if (load_p1 && in_valid_i) begin
            rnd_p1     <= rnd_p0;
            inexact_p1 <= inexact_p0;
            sat_p1     <= sat_en_i;
        end
    end

    // ---- stage 1 -> 2: range check, saturate, register outputs ----
    assign sat_res_p1 = saturate(rnd_p1, sat_p1);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_p2     <= 1'b0;
            fixed_p2   <= '0;
            ovf_p2     <= 1'b0;
            inexact_p2 <= 1'b0;
        end else if (load_p2) begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                fixed_p2   <= sat_res_p1[W_OUT-1:0];
                ovf_p2     <= sat_res_p1[W_OUT];
                inexact_p2 <= inexact_p1;
            end
        end
    end

    // ---- output handshake: overflow event counter ----
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            ovf_count <= '0;
        else if (clr_count_i)
            ovf_count <= '0;
        else if (vld_p2 && out_ready_i && ovf_p2 && (ovf_count != {CNT_W{1'b1}}))
            ovf_count <= ovf_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    assign out_valid_o = vld_p2;
    assign fixed_o     = fixed_p2;
    assign ovf_o       = ovf_p2;
    assign inexact_o   = inexact_p2;
    assign ovf_count_o = ovf_count;

endmodule
